// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS-style controller: opcodes,
// state codes, datapath select codes and the control word layout.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic       pcwrite;
    logic       branch;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{default: '0};

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      default:                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller-to-datapath bundle: instruction opcode and memory handshake in,
// datapath controls and debug state out.
interface multicycle_control_if;
  import multicycle_control_pkg::*;

  logic [5:0] op;
  logic       mem_ready;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic       PCWrite;
  logic       Branch;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    output op, mem_ready,
    input  IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
           PCWrite, Branch, ALUSrcB, ALUOp, PCSrc, illegal_op, state
  );

  modport slave (
    input  op, mem_ready,
    output IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
           PCWrite, Branch, ALUSrcB, ALUOp, PCSrc, illegal_op, state
  );

endinterface

// File: rtl/multicycle_control_output_decode.sv
// Moore output decode: maps the controller state to its datapath control word.
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Per-state control word; every field not named for a state stays zero.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQ: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: begin
        ctrl = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor controller: state register and next-state logic, with
// the Moore output decode delegated to mc_output_decode.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.slave bus
);

  state_t state_r;
  state_t state_next_s;
  ctrl_t  ctrl_s;
  logic   fetch_gate_s;
  logic   illegal_s;

  // State register; reset drops any in-flight instruction back to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (bus.mem_ready) state_next_s = S_DECODE;
        else               state_next_s = S_FETCH;
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_RTYPE:     state_next_s = S_RTYPEEX;
          OP_BEQ:       state_next_s = S_BEQ;
          OP_ADDI:      state_next_s = S_ADDIEX;
          OP_J:         state_next_s = S_JUMP;
          default:      state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_SW) state_next_s = S_MEMWR;
        else                 state_next_s = S_MEMRD;
      end
      S_MEMRD: begin
        if (bus.mem_ready) state_next_s = S_MEMWB;
        else               state_next_s = S_MEMRD;
      end
      S_MEMWR: begin
        if (bus.mem_ready) state_next_s = S_FETCH;
        else               state_next_s = S_MEMWR;
      end
      S_RTYPEEX: state_next_s = S_ALUWB;
      S_ADDIEX:  state_next_s = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_ADDIWB, S_JUMP: state_next_s = S_FETCH;
      default:   state_next_s = S_FETCH;
    endcase
  end

  // FETCH writes IR/PC only on the cycle memory delivers, never under reset.
  always_comb begin
    fetch_gate_s = 1'b1;
    illegal_s    = 1'b0;
    if (state_r == S_FETCH) begin
      fetch_gate_s = bus.mem_ready & ~rst;
    end else begin
      fetch_gate_s = 1'b1;
    end
    if (state_r == S_DECODE) begin
      illegal_s = ~op_supported(bus.op);
    end else begin
      illegal_s = 1'b0;
    end
  end

  mc_output_decode u_decode (
    .state (state_r),
    .ctrl  (ctrl_s)
  );

  assign bus.IorD       = ctrl_s.iord;
  assign bus.MemWrite   = ctrl_s.memwrite;
  assign bus.IRWrite    = ctrl_s.irwrite & fetch_gate_s;
  assign bus.RegWrite   = ctrl_s.regwrite;
  assign bus.RegDst     = ctrl_s.regdst;
  assign bus.MemtoReg   = ctrl_s.memtoreg;
  assign bus.ALUSrcA    = ctrl_s.alusrca;
  assign bus.PCWrite    = ctrl_s.pcwrite & fetch_gate_s;
  assign bus.Branch     = ctrl_s.branch;
  assign bus.ALUSrcB    = ctrl_s.alusrcb;
  assign bus.ALUOp      = ctrl_s.aluop;
  assign bus.PCSrc      = ctrl_s.pcsrc;
  assign bus.illegal_op = illegal_s;
  assign bus.state      = state_r;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; opcode encodings and state codes SHALL come from the shared package.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  opcode field of the instruction register (bits 31:26).
REQ-005 mem_ready  input  1  memory handshake; high when the current memory access completes this cycle.
REQ-006 IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, PCWrite, Branch  output  1 each  datapath controls.
REQ-007 ALUSrcB, ALUOp, PCSrc  output  2 each  datapath select codes.
REQ-008 illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
REQ-009 state  output  4  current state code, for debug.

Function
REQ-010 The block SHALL be a Moore FSM with these 12 states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQ, ADDIEX, ADDIWB, JUMP.
REQ-011 Supported opcodes SHALL be R-type=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
REQ-012 FETCH outputs: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite SHALL be 1 only when mem_ready=1.
REQ-013 FETCH SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-014 DECODE outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-015 DECODE transitions:
  - lw or sw -> MEMADR
  - R-type -> RTYPEEX
  - beq -> BEQ
  - addi -> ADDIEX
  - j -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 for that cycle
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD for lw, MEMWR for sw.
REQ-017 MEMRD: IorD=1. Hold while mem_ready=0; go to MEMWB on mem_ready=1.
REQ-018 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
REQ-019 MEMWR: IorD=1, MemWrite=1. Hold while mem_ready=0; go to FETCH on mem_ready=1.
REQ-020 RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALUWB.
REQ-021 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Go to FETCH.
REQ-022 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Go to FETCH.
REQ-023 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
REQ-024 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Go to FETCH.
REQ-025 JUMP: PCSrc=10, PCWrite=1. Go to FETCH.
REQ-026 Every output not listed for a state SHALL be 0, or 00 for 2-bit outputs.
REQ-027 Outputs SHALL be a combinational decode of the state register only. The one exception is mem_ready gating of IRWrite and PCWrite in FETCH.
REQ-028 Instruction latency without stalls, counted from FETCH entry back to FETCH:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
REQ-029 Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle to that latency.
REQ-030 An unreachable state code SHALL go to FETCH on the next clock.

Reset
REQ-031 Asserting rst SHALL force state to FETCH immediately, independent of clk, including mid-instruction. Any in-flight write SHALL be abandoned.
REQ-032 While rst is high, every output SHALL be 0, except the FETCH select codes: ALUSrcB=01, PCSrc=00, ALUOp=00.
REQ-033 After rst deasserts, the first rising edge of clk SHALL evaluate FETCH with mem_ready.

Structure
REQ-034 A shared package SHALL hold the opcode constants, the 4-bit state enumeration, and the ALUOp and PCSrc code constants.
REQ-035 The output decode SHALL be a sub-module, mc_output_decode (state in, control word out). The next-state logic and the state register SHALL remain in multicycle_control.

Verification
REQ-036 lw, mem_ready tied 1: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. RegWrite=1, MemtoReg=1 and RegDst=0 only in cycle 5.
REQ-037 R-type: ALUWB reached in cycle 4 with RegDst=1 and RegWrite=1. ALUOp=10 in cycle 3.
REQ-038 sw with mem_ready low for 3 cycles in MEMWR: MemWrite=1 for 4 consecutive cycles, then FETCH.
REQ-039 op=111111 in DECODE: illegal_op=1 for one cycle, next state FETCH, RegWrite and MemWrite never asserted.
REQ-040 rst pulsed asynchronously during ADDIWB: state=FETCH and RegWrite=0 before the next clk edge. After release, a j instruction completes in 3 cycles with PCSrc=10.
REQ-041 FETCH with mem_ready=0 for 2 cycles: IRWrite=0 and PCWrite=0 in both cycles. IRWrite=1 and PCWrite=1 in the cycle mem_ready rises, then DECODE.
